fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares a single synchronous FIFO write port between `NUM_REQ` packet sources. Grants are locked per packet, with a burst cap for fairness. Beats transfer only while the FIFO is not full. It sits directly in front of the team's sync FIFO and drives its `din`/`wr_en`, observing `full`.

## Interface
- `DATA_WIDTH`, 8, beat width; matches FIFO `DATA_WIDTH`
- `NUM_REQ`, 4, number of requesters (2..16)
- `MAX_BURST`, 16, max beats per grant before forced release (1..256)
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester beat valid
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed beats; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_last`  in  NUM_REQ  final beat of packet
- `req_ready`  out  NUM_REQ  beat accepted this cycle when ANDed with `req_valid`
- `fifo_din`  out  DATA_WIDTH  to FIFO `din`
- `fifo_wr_en`  out  1  to FIFO `wr_en`
- `fifo_full`  in  1  from FIFO `full`
- `grant_id`  out  max(1,clog2(NUM_REQ))  current owner; valid when `busy`
- `busy`  out  1  a grant is held

## Operation
- States:
  - IDLE: no grant.
  - BURST: grant locked to `grant_id`.
- IDLE → BURST: any `req_valid` bit set. Winner is the first set bit scanning upward, circularly, from `last_grant+1`. `grant_id` ← winner. Beat counter ← 0.
- In BURST, a beat transfers when `req_valid[grant_id] & ~fifo_full`:
  - `fifo_wr_en` = transfer, `fifo_din` = `req_data` slice of `grant_id`.
  - `req_ready[grant_id]` = `busy & ~fifo_full`. All other `req_ready` bits are 0.
- Beat counter increments on each transfer and saturates at `MAX_BURST`.
- BURST → IDLE when a transfer occurs with `req_last[grant_id]=1`, or when the transfer makes the counter equal `MAX_BURST`. `last_grant` ← `grant_id` on the same edge.
- A forced release mid-packet lets other requesters in. The preempted source resumes its packet at its next grant; packet boundaries are the source's concern.
- `req_valid` dropping during BURST stalls without releasing the grant. There is no timeout.
- `fifo_full`: no transfer and no state change. Data is held by the source (valid/ready rule).
- `fifo_wr_en` is never asserted while `fifo_full=1` or in IDLE. It never overwrites FIFO contents.

## Timing
- Reset (async assert, sync deassert by the system): state=IDLE, `busy`=0, `grant_id`=0, `last_grant`=NUM_REQ-1 (so requester 0 wins first), counter=0.
- Reset outputs: `req_ready`=0, `fifo_wr_en`=0, `fifo_din`=0. Outputs take these values immediately on assertion, including mid-burst.
- Arbitration latency: `req_valid` seen high in IDLE at edge N → `busy`/`grant_id` valid after N. First beat can transfer in cycle N+1.
- After a release, IDLE lasts exactly one cycle, so the next grant's first beat is ≥2 cycles after the last beat.
- `fifo_din`, `fifo_wr_en` and `req_ready` are combinational from registered grant state, `req_valid`/`req_data`, and `fifo_full`. There is no combinational path from `req_*` to `req_ready`.
- Single-beat packet (`req_last` on first beat): BURST for exactly one transfer cycle.
- `MAX_BURST=1`: every grant is one beat, giving strict per-beat round-robin.
- Simultaneous `req_last` and counter reaching `MAX_BURST`: a single release.

## Structure
- Package `fifo_arb_pkg`:
  - state encodings `ST_IDLE`, `ST_BURST`
  - clog2 helper function shared with the FIFO address-width logic
- Sub-module `rr_pick` (combinational):
  - inputs: `req[NUM_REQ]`, `last[clog2]`
  - outputs: `winner[clog2]`, `any`
  - Implemented as a rotate, priority-encode, then un-rotate. It is reusable by other schedulers in the library.
- Top level holds the state register, grant/last_grant registers, beat counter and output muxing.

## Test plan
- Reset then all four `req_valid`=1, each sending a 2-beat packet, FIFO empty: grants in order 0,1,2,3,0. Each grant writes 2 beats, with one IDLE cycle between grants.
- Requester 2 sends a 40-beat packet, `MAX_BURST`=16, requester 1 also requesting: writes of 2×16, 1's packet, 2×… Exactly 16 beats per grant. All data arrives in the FIFO in order per source.
- `fifo_full` held high for 5 cycles mid-burst: `fifo_wr_en`=0 and `req_ready`=0 for those cycles. No beat is lost or duplicated, and the counter is unchanged.
- Granted source drops `req_valid` for 3 cycles: grant held, `busy`=1, no transfers. Other requesters stay stalled.
- `reset_n` pulsed low mid-burst: outputs go to reset values the same cycle with no clock edge. After release, requester 0 wins first.
- Random valid/last/full traffic with NUM_REQ=3, 10k cycles, checked against a scoreboard:
  - FIFO contents equal the per-source interleaving dictated by round-robin.
  - No source is starved for more than (NUM_REQ-1)×(MAX_BURST+1) transfer-eligible cycles.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter and its neighbours.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Same ceil-log2 the FIFO uses for its address width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Source-side beat handshakes plus the FIFO write port, bundled for the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    localparam int GW = fifo_arb_pkg::id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          fifo_wr_en;
    logic                          fifo_full;
    logic [GW-1:0]                 grant_id;
    logic                          busy;

    // Arbiter view: it masters the FIFO write port.
    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_din, fifo_wr_en, grant_id, busy
    );

    // Environment view: packet sources and the FIFO's full flag.
    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_din, fifo_wr_en, grant_id, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning up from last+1.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int W       = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [W-1:0]       last,
    output logic [W-1:0]       winner,
    output logic               any
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   start;
    int                   idx;
    int                   sum;

    // Rotate so the oldest-served neighbour sits at bit 0, pick lowest, rotate back.
    always_comb begin
        start = int'(last) + 1;
        if (start >= NUM_REQ) start = 0;
        dbl = {req, req};
        rot = NUM_REQ'(dbl >> start);
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) idx = i;
        end
        sum = start + idx;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        winner = W'(sum);
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked write arbiter in front of the sync FIFO, with a
// per-grant burst cap so one long packet cannot hog the port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int              GW      = id_width(NUM_REQ);
    localparam int              CW      = clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_BURST);

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [GW-1:0] winner;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          any_req;
    logic          busy;
    logic          xfer;
    logic          release_grant;

    rr_pick #(.NUM_REQ(NUM_REQ), .W(GW)) u_pick (
        .req    (bus.req_valid),
        .last   (last_q),
        .winner (winner),
        .any    (any_req)
    );

    assign busy          = (state_q == ST_BURST);
    assign xfer          = busy & bus.req_valid[grant_q] & ~bus.fifo_full;
    assign cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign release_grant = bus.req_last[grant_q] | (cnt_inc == CNT_MAX);

    // Ready depends only on registered grant and full, never on req_*.
    always_comb begin
        bus.req_ready = '0;
        if (busy && !bus.fifo_full) bus.req_ready[grant_q] = 1'b1;
    end

    assign bus.fifo_wr_en = xfer;
    assign bus.fifo_din   = busy ? bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = busy;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_BURST;
                    grant_d = winner;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (release_grant) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_q starts at NUM_REQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
